// File: rtl/ballot_controller.sv
// ----------------------------------------------------------------------------
// ballot_controller
//
// Per-voter ballot front end feeding the vote logger. Four raw candidate
// buttons are synchronised and debounced; a ballot is armed when the officer
// grants one while voting is open, and exactly one clean single-candidate
// press per grant produces a one-cycle one-hot valid_vote pulse.
//
// Ports:
//   clock          single clock, rising-edge
//   reset          asynchronous active-high reset
//   voting_open    session enable; low blocks grants and aborts an armed ballot
//   ballot_enable  officer grant, sampled as a level in IDLE
//   button[3:0]    raw asynchronous buttons, bit i = candidate i+1
//   valid_vote     registered one-cycle one-hot vote pulse
//   ballot_ready   registered, high while a ballot is armed
//   invalid_press  registered one-cycle pulse on a rejected multi-button press
//   ballot_timeout registered one-cycle pulse when an armed ballot expires
// ----------------------------------------------------------------------------
module ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       voting_open,
  input  logic       ballot_enable,
  input  logic [3:0] button,
  output logic [3:0] valid_vote,
  output logic       ballot_ready,
  output logic       invalid_press,
  output logic       ballot_timeout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COMMIT,
    HOLD_DONE,
    HOLD_RETRY
  } state_t;

  state_t        state_q;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    db_q, db_d;
  logic [3:0]    db_prev_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [TW-1:0] tcnt_q;
  logic [3:0]    valid_vote_q;
  logic          ready_q, invalid_q, timeout_q;
  logic          newPress, oneHot;

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a bit flips only after it has disagreed with its debounced
  // value for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A press counts only as a rising edge out of the all-released state, so
  // buttons already held when the ballot arms can never cast a vote.
  assign newPress = (db_prev_q == 4'b0000) && (db_q != 4'b0000);
  assign oneHot   = $onehot(db_q);

  // Ballot FSM with registered outputs; the pulse outputs default low and
  // are raised on the transition edge so they appear in the following cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      valid_vote_q <= '0;
      ready_q      <= 1'b0;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      valid_vote_q <= '0;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (voting_open && ballot_enable) begin
            state_q <= ARMED;
            tcnt_q  <= '0;
            ready_q <= 1'b1;
          end
        end
        ARMED: begin
          if (!voting_open) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end else if (newPress && oneHot) begin
            state_q      <= COMMIT;
            valid_vote_q <= db_q;
            ready_q      <= 1'b0;
          end else if (newPress) begin
            state_q   <= HOLD_RETRY;
            invalid_q <= 1'b1;
            ready_q   <= 1'b0;
          end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LAST)) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        COMMIT: begin
          state_q <= HOLD_DONE;
        end
        HOLD_DONE: begin
          if (db_q == 4'b0000) state_q <= IDLE;
        end
        HOLD_RETRY: begin
          // The ballot survives a rejected press; it re-arms with a fresh timeout.
          if (db_q == 4'b0000) begin
            state_q <= ARMED;
            tcnt_q  <= '0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_vote     = valid_vote_q;
  assign ballot_ready   = ready_q;
  assign invalid_press  = invalid_q;
  assign ballot_timeout = timeout_q;

endmodule

// File: doc/ballot_controller.md
# ballot_controller

Per-voter ballot front end that sits directly upstream of the vote logger and drives its `valid_vote[3:0]` input. It synchronises and debounces four raw candidate buttons and arms a single ballot when the presiding officer grants one. It accepts exactly one clean single-candidate press per granted ballot and emits a one-cycle one-hot `valid_vote` pulse, so the logger counts at most one vote per grant.

## Interface
- `DEBOUNCE_CYCLES`, default 8: consecutive cycles a synchronised button must differ from its debounced value before the debounced value toggles; legal range ≥ 1.
- `TIMEOUT_CYCLES`, default 1000: cycles an armed ballot waits for a press before it is withdrawn; 0 disables the timeout.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `voting_open`  in  1  session enable; a low level blocks grants and aborts an armed ballot.
- `ballot_enable`  in  1  officer grant, sampled as a level each cycle.
- `button`  in  4  raw, asynchronous candidate buttons; bit i corresponds to candidate i+1.
- `valid_vote`  out  4  registered one-cycle one-hot vote pulse to the logger.
- `ballot_ready`  out  1  registered; high while the state is ARMED.
- `invalid_press`  out  1  registered one-cycle pulse on a rejected multi-button press.
- `ballot_timeout`  out  1  registered one-cycle pulse when an armed ballot expires.

## Operation
- Input conditioning, per bit:
  - Two-flop synchroniser produces `sync[i]`.
  - Debouncer holds `db[i]` and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter increments in each cycle where `sync[i]` ≠ `db[i]` and clears in each cycle where they are equal.
  - When the counter is DEBOUNCE_CYCLES-1 and the bits still differ, `db[i]` toggles at the next edge and the counter clears.
- `db_prev` register holds the previous cycle's `db`; a *new press* is `db_prev`==0 and `db`≠0.
- FSM states: IDLE, ARMED, COMMIT, HOLD_DONE, HOLD_RETRY.
  - IDLE: moves to ARMED when `voting_open` and `ballot_enable` are both high. The timeout counter is cleared on entry to ARMED.
  - ARMED, in priority order:
    1. `voting_open` low → IDLE.
    2. New press, one-hot → COMMIT.
    3. New press, two or more bits → HOLD_RETRY.
    4. TIMEOUT_CYCLES≠0 and timeout counter == TIMEOUT_CYCLES-1 → IDLE.
    5. Otherwise the timeout counter increments.
  - COMMIT: lasts one cycle, then → HOLD_DONE.
  - HOLD_DONE: waits for `db`==0, then → IDLE. This forces release before the next voter.
  - HOLD_RETRY: waits for `db`==0, then → ARMED. The ballot is not consumed and the timeout counter clears.
- Buttons already held (`db`≠0) when ARMED is entered do not form a new press; a vote is accepted only after all buttons have been released and one is pressed.
- While in ARMED, `ballot_enable` is ignored. A new grant is required after each return to IDLE.
- Outputs:
  - `valid_vote` equals `db` (one-hot) during the COMMIT cycle and 0 otherwise.
  - `invalid_press` is high in the first cycle of HOLD_RETRY.
  - `ballot_timeout` is high in the cycle after the expiry transition.
- Reset values: all outputs 0, state IDLE, all counters, synchronisers, `db` and `db_prev` 0. Asserting reset mid-ballot discards the ballot with no vote pulse.

## Timing
- Raw press first sampled high at edge E0 and held steady: `sync` is high after E1, `db` toggles at edge E1+DEBOUNCE_CYCLES, and the FSM enters COMMIT at E2+DEBOUNCE_CYCLES. `valid_vote` is high for exactly that one cycle, i.e. DEBOUNCE_CYCLES+2 edges after E0.
- A glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation never changes `db`.
- Grant latency: `ballot_ready` rises at the edge after `ballot_enable` is sampled high in IDLE.
- At most one nonzero `valid_vote` cycle occurs per IDLE→ARMED transition.
- `valid_vote`, `invalid_press` and `ballot_timeout` are mutually exclusive in any cycle.

## Test plan
- DEBOUNCE_CYCLES=4: reset, grant, clean press on `button[2]` → single `valid_vote`=4'b0100 exactly 6 edges after first sample, then `ballot_ready`=0. Release → IDLE.
- Grant, then 3-cycle pulse on `button[0]` → no `valid_vote`, `ballot_ready` stays 1. Follow with a stable press → `valid_vote`=4'b0001.
- Grant, then `button[1]` and `button[3]` pressed together → `invalid_press` one cycle, no vote. Release both, press `button[3]` → `valid_vote`=4'b1000.
- Hold `button[0]` through the grant → no vote. Release, then press `button[1]` → `valid_vote`=4'b0010. Hold `button[1]` and re-assert `ballot_enable` → stays HOLD_DONE, no second vote.
- TIMEOUT_CYCLES=20: grant with no press → `ballot_timeout` pulse, `ballot_ready`=0 after 20 ARMED cycles. Dropping `voting_open` while ARMED → IDLE with no pulse.
- Assert `reset` during COMMIT's preceding debounce window → all outputs 0 at once, and no vote follows after reset is released.
